spi_ram_ctrl: RTL and testbench
===============================

Name: spi_ram_ctrl

Overview:
- Memory stage directly downstream of the SPI slave FSM (IDLE/CHK_CMD/WRITE/READ_ADD/READ_DATA).
- Consumes each 10-bit frame the slave assembles from MOSI: bits [9:8] = command, bits [7:0] = payload.
- Executes write-address, write-data, read-address and read-data commands on a single-port byte RAM.
- Returns read bytes to the slave for shifting out on MISO, and flags out-of-order command sequences.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words; must equal 2**ADDR_SIZE.
- ADDR_SIZE, 8, address width; taken from din[ADDR_SIZE-1:0]; 1..8.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  10  frame from SPI slave; [9:8] command, [7:0] payload.
- rx_valid  input  1  din valid this cycle; single-cycle strobe per frame.
- dout  output  8  read byte for the SPI slave.
- tx_valid  output  1  dout valid; held until the next accepted frame.
- seq_err  output  1  one-cycle pulse on an out-of-order command.

Behaviour:
- Reset (async, rst_n=0): dout=0, tx_valid=0, seq_err=0, wr_addr=0, rd_addr=0, wr_addr_vld=0, rd_addr_vld=0.
- RAM contents are not reset.
- Reset asserted mid-operation aborts any pending read; nothing is written in the reset cycle.
- A frame is accepted only on a posedge with rx_valid=1; with rx_valid=0 all state holds.
- Command 00 (write address):
  - wr_addr <= din[ADDR_SIZE-1:0]; wr_addr_vld <= 1.
- Command 01 (write data):
  - If wr_addr_vld=1: mem[wr_addr] <= din[7:0], written at this edge.
  - wr_addr_vld stays 1, so repeated 01 frames overwrite the same address.
  - If wr_addr_vld=0: no write; seq_err=1 for one cycle.
- Command 10 (read address):
  - rd_addr <= din[ADDR_SIZE-1:0]; rd_addr_vld <= 1.
- Command 11 (read data):
  - din[7:0] is a don't-care.
  - If rd_addr_vld=1: dout <= mem[rd_addr] and tx_valid <= 1 at this edge.
  - Latency is 1 clock from the accepting edge; dout/tx_valid are visible the following cycle.
  - If rd_addr_vld=0: dout holds, tx_valid <= 0, seq_err=1 for one cycle.
- tx_valid rules:
  - Stays 1, with dout stable, through any cycles with rx_valid=0.
  - Cleared at the edge of the next accepted frame with command 00, 01 or 10.
  - Back-to-back 11 frames keep tx_valid=1 and refresh dout.
- Read-during-write: 11 with rd_addr==wr_addr returns the previously written value.
  - A write and a read never coincide in one frame.
- Address wrap: payload bits above ADDR_SIZE-1 are ignored.
- seq_err: registered; high exactly one cycle after the offending edge; never high in consecutive cycles unless offending frames are back-to-back.
- Internal state is two independent sequencers:
  - Write: W_NOADDR -> W_ADDR on 00; stays W_ADDR on 01.
  - Read: R_NOADDR -> R_ADDR on 10; R_ADDR -> R_DATA on 11 (tx_valid=1).
  - R_DATA -> R_ADDR on any non-11 frame; R_DATA -> R_DATA on 11.
  - Reset returns both sequencers to NOADDR.
- All four din[9:8] encodings are legal; there is no invalid-command path.

Optional Feature:
- Macro: SPI_RAM_AUTOINC_EN.
- Defined:
  - Each successful 01 post-increments wr_addr modulo MEM_DEPTH.
  - Each successful 11 post-increments rd_addr modulo MEM_DEPTH (255 -> 0 at defaults).
  - A 00 or 10 frame reloads the pointer.
  - Failed 01/11 frames (seq_err) do not increment.
- Undefined: pointers change only on 00/10 frames.

Test Plan:
- Reset then 00/0x3C, 01/0xA5, 10/0x3C, 11 -> cycle after the 11 edge: dout=0xA5, tx_valid=1, seq_err never 1.
- After reset, 01/0x55 with no prior 00 -> seq_err pulses once, no RAM write; then 00/0x00, 10/0x00, 11 -> dout=old mem[0], not 0x55.
- After a valid read (tx_valid=1): idle 20 cycles -> tx_valid=1 and dout stable; then 10/0x01 -> tx_valid=0 next cycle.
- Back-to-back: 00/0x10, 01/0x11, 01/0x22, 10/0x10, 11, 11 -> dout=0x22 on both reads without SPI_RAM_AUTOINC_EN.
- With SPI_RAM_AUTOINC_EN: 00/0xFF, 01/0xAA, 01/0xBB, 10/0xFF, 11, 11 -> dout=0xAA then 0xBB (address wrapped 255->0).
- Assert rst_n=0 for 1 cycle while tx_valid=1 and rd_addr_vld=1 -> dout=0, tx_valid=0 immediately; a following 11 frame -> seq_err=1, tx_valid stays 0.

Source files
------------

// File: rtl/spi_ram_ctrl_if.sv
// rtl/spi_ram_ctrl_if.sv - frame/read-back bus between the SPI slave FSM and the RAM stage
// master drives frames (SPI slave side), slave consumes them (RAM controller side).
interface spi_ram_ctrl_if;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       seq_err;

    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid,
        input  seq_err
    );

    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid,
        output seq_err
    );
endinterface

// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - SPI frame driven single-port byte RAM with write/read address sequencers
// Optional SPI_RAM_AUTOINC_EN: successful data frames post-increment their address pointer.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_ram_ctrl_if.slave bus
);

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic {
        W_NOADDR,
        W_ADDR
    } wr_state_t;

    typedef enum logic [1:0] {
        R_NOADDR,
        R_ADDR,
        R_DATA
    } rd_state_t;

    wr_state_t            r_wr_state;
    wr_state_t            w_wr_state_nxt;
    rd_state_t            r_rd_state;
    rd_state_t            w_rd_state_nxt;

    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic [ADDR_SIZE-1:0] w_wr_addr_nxt;
    logic [ADDR_SIZE-1:0] w_rd_addr_nxt;
    logic [7:0]           r_dout;
    logic [7:0]           w_dout_nxt;
    logic                 r_seq_err;
    logic                 w_seq_err_nxt;
    logic                 w_wr_en;

    logic [7:0]           r_mem [0:MEM_DEPTH-1];

    logic [1:0]           w_cmd;
    logic [7:0]           w_payload;
    logic [ADDR_SIZE-1:0] w_addr_field;
    logic                 w_wr_addr_vld;
    logic                 w_rd_addr_vld;

    assign w_cmd         = bus.din[9:8];
    assign w_payload     = bus.din[7:0];
    assign w_addr_field  = bus.din[ADDR_SIZE-1:0];
    assign w_wr_addr_vld = (r_wr_state == W_ADDR);
    assign w_rd_addr_vld = (r_rd_state != R_NOADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_state <= W_NOADDR;
            r_rd_state <= R_NOADDR;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_rd_state_nxt = r_rd_state;
        w_wr_addr_nxt  = r_wr_addr;
        w_rd_addr_nxt  = r_rd_addr;
        w_dout_nxt     = r_dout;
        w_seq_err_nxt  = 1'b0;
        w_wr_en        = 1'b0;

        if (bus.rx_valid) begin
            // Any accepted non-read-data frame ends the read-back window.
            if (w_cmd != CMD_RD_DATA && r_rd_state == R_DATA) begin
                w_rd_state_nxt = R_ADDR;
            end

            case (w_cmd)
                CMD_WR_ADDR: begin
                    w_wr_state_nxt = W_ADDR;
                    w_wr_addr_nxt  = w_addr_field;
                end
                CMD_WR_DATA: begin
                    if (w_wr_addr_vld) begin
                        w_wr_en = rst_n;
`ifdef SPI_RAM_AUTOINC_EN
                        w_wr_addr_nxt = r_wr_addr + 1'b1;
`endif
                    end else begin
                        w_seq_err_nxt = 1'b1;
                    end
                end
                CMD_RD_ADDR: begin
                    w_rd_state_nxt = R_ADDR;
                    w_rd_addr_nxt  = w_addr_field;
                end
                default: begin
                    if (w_rd_addr_vld) begin
                        w_rd_state_nxt = R_DATA;
                        w_dout_nxt     = r_mem[r_rd_addr];
`ifdef SPI_RAM_AUTOINC_EN
                        w_rd_addr_nxt = r_rd_addr + 1'b1;
`endif
                    end else begin
                        w_seq_err_nxt = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_dout    <= 8'h00;
            r_seq_err <= 1'b0;
        end else begin
            r_wr_addr <= w_wr_addr_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_dout    <= w_dout_nxt;
            r_seq_err <= w_seq_err_nxt;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_addr] <= w_payload;
        end
    end

    assign bus.dout     = r_dout;
    assign bus.tx_valid = (r_rd_state == R_DATA);
    assign bus.seq_err  = r_seq_err;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb/tb_spi_ram_ctrl.sv - self-checking bench for spi_ram_ctrl (vector table, directed and random frames)
module tb_spi_ram_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_ram_ctrl_if bus ();

    spi_ram_ctrl #(
        .MEM_DEPTH(256),
        .ADDR_SIZE(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] m_mem [256];
    logic [7:0] m_wptr, m_rptr, m_dout;
    logic       m_wvld, m_rvld, m_txv, m_serr;

    typedef struct {
        logic       v;
        logic [1:0] cmd;
        logic [7:0] pay;
        logic       chk_dout;
        logic [7:0] dout;
        logic       txv;
        logic       serr;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic v, input logic [1:0] cmd, input logic [7:0] pay,
                           input logic chk_dout, input logic [7:0] dout,
                           input logic txv, input logic serr);
        vec_t e;
        e.v = v; e.cmd = cmd; e.pay = pay; e.chk_dout = chk_dout;
        e.dout = dout; e.txv = txv; e.serr = serr;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wptr = 8'h00; m_rptr = 8'h00; m_dout = 8'h00;
        m_wvld = 1'b0;  m_rvld = 1'b0;  m_txv = 1'b0; m_serr = 1'b0;
    endtask

    // Reference behaviour of one clock edge, written from the command rules.
    task automatic model_edge(input logic v, input logic [1:0] cmd, input logic [7:0] pay);
        m_serr = 1'b0;
        if (v) begin
            if (cmd == 2'd0) begin
                m_wptr = pay; m_wvld = 1'b1; m_txv = 1'b0;
            end else if (cmd == 2'd1) begin
                m_txv = 1'b0;
                if (m_wvld) begin
                    m_mem[m_wptr] = pay;
`ifdef SPI_RAM_AUTOINC_EN
                    m_wptr = 8'((int'(m_wptr) + 1) % 256);
`endif
                end else begin
                    m_serr = 1'b1;
                end
            end else if (cmd == 2'd2) begin
                m_rptr = pay; m_rvld = 1'b1; m_txv = 1'b0;
            end else begin
                if (m_rvld) begin
                    m_dout = m_mem[m_rptr];
                    m_txv  = 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                    m_rptr = 8'((int'(m_rptr) + 1) % 256);
`endif
                end else begin
                    m_txv  = 1'b0;
                    m_serr = 1'b1;
                end
            end
        end
    endtask

    // Entered and left at a negedge; one call is one clock cycle.
    task automatic step(input logic v, input logic [1:0] cmd, input logic [7:0] pay);
        bus.rx_valid = v;
        bus.din      = {cmd, pay};
        @(posedge clk);
        model_edge(v, cmd, pay);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        check("model_dout", bus.dout, m_dout);
        check("model_tx_valid", {7'b0, bus.tx_valid}, {7'b0, m_txv});
        check("model_seq_err", {7'b0, bus.seq_err}, {7'b0, m_serr});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("reset_dout", bus.dout, 8'h00);
        check("reset_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
        check("reset_seq_err", {7'b0, bus.seq_err}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] x1, x2, y1;

    initial begin
        bus.din = '0;
        bus.rx_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Known background: mem[i] = i ^ 0x5A
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 2'd0, 8'(i));
            step(1'b1, 2'd1, 8'(i) ^ 8'h5A);
        end

        // Write data before any write address: error pulse, RAM untouched
        do_reset();
        step(1'b1, 2'd1, 8'h55);
        check("early_wr_seq_err", {7'b0, bus.seq_err}, 8'h01);
        step(1'b0, 2'd0, 8'h00);
        check("seq_err_one_cycle", {7'b0, bus.seq_err}, 8'h00);
        step(1'b1, 2'd0, 8'h00);
        step(1'b1, 2'd2, 8'h00);
        step(1'b1, 2'd3, 8'h00);
        check("old_mem0", bus.dout, 8'h5A);

        // Read-back held through idle, then dropped by a read-address frame
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 2'd0, 8'h00);
            check("idle_tx_valid", {7'b0, bus.tx_valid}, 8'h01);
            check("idle_dout", bus.dout, 8'h5A);
        end
        step(1'b1, 2'd2, 8'h01);
        check("tx_valid_cleared", {7'b0, bus.tx_valid}, 8'h00);

        // Reset during an active read aborts it
        step(1'b1, 2'd3, 8'h00);
        check("pre_reset_dout", bus.dout, 8'h5B);
        check("pre_reset_tx_valid", {7'b0, bus.tx_valid}, 8'h01);
        do_reset();
        step(1'b1, 2'd3, 8'h00);
        check("post_reset_rd_seq_err", {7'b0, bus.seq_err}, 8'h01);
        check("post_reset_tx_valid", {7'b0, bus.tx_valid}, 8'h00);
        step(1'b0, 2'd0, 8'h00);
        check("post_reset_seq_err_clr", {7'b0, bus.seq_err}, 8'h00);

`ifdef SPI_RAM_AUTOINC_EN
        x1 = 8'h11; x2 = 8'h22; y1 = 8'hAA;
`else
        x1 = 8'h22; x2 = 8'h22; y1 = 8'hBB;
`endif
        add_vec(1, 2'd0, 8'h3C, 0, 8'h00, 0, 0);
        add_vec(1, 2'd1, 8'hA5, 0, 8'h00, 0, 0);
        add_vec(1, 2'd2, 8'h3C, 0, 8'h00, 0, 0);
        add_vec(1, 2'd3, 8'h00, 1, 8'hA5, 1, 0);
        add_vec(1, 2'd0, 8'h10, 1, 8'hA5, 0, 0);
        add_vec(1, 2'd1, 8'h11, 0, 8'h00, 0, 0);
        add_vec(1, 2'd1, 8'h22, 0, 8'h00, 0, 0);
        add_vec(1, 2'd2, 8'h10, 0, 8'h00, 0, 0);
        add_vec(1, 2'd3, 8'h00, 1, x1,    1, 0);
        add_vec(1, 2'd3, 8'h00, 1, x2,    1, 0);
        add_vec(1, 2'd0, 8'hFF, 0, 8'h00, 0, 0);
        add_vec(1, 2'd1, 8'hAA, 0, 8'h00, 0, 0);
        add_vec(1, 2'd1, 8'hBB, 0, 8'h00, 0, 0);
        add_vec(1, 2'd2, 8'hFF, 0, 8'h00, 0, 0);
        add_vec(1, 2'd3, 8'h00, 1, y1,    1, 0);
        add_vec(1, 2'd3, 8'h00, 1, 8'hBB, 1, 0);
        add_vec(0, 2'd1, 8'h00, 1, 8'hBB, 1, 0);

        do_reset();
        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].cmd, vecs[i].pay);
            if (vecs[i].chk_dout) check("vec_dout", bus.dout, vecs[i].dout);
            check("vec_tx_valid", {7'b0, bus.tx_valid}, {7'b0, vecs[i].txv});
            check("vec_seq_err", {7'b0, bus.seq_err}, {7'b0, vecs[i].serr});
        end

        // Random frames, biased towards low/wrapping addresses, with occasional resets
        for (int i = 0; i < 600; i++) begin
            logic       rv;
            logic [1:0] rc;
            logic [7:0] rp;
            if ($urandom_range(0, 63) == 0) begin
                do_reset();
            end else begin
                rv = ($urandom_range(0, 3) != 0);
                rc = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 2))
                    0:       rp = 8'($urandom_range(0, 3));
                    1:       rp = 8'($urandom_range(252, 255));
                    default: rp = 8'($urandom);
                endcase
                step(rv, rc, rp);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
